// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, instruction-format enum and range-check helper
// used by the instruction encoder and its packing sub-module.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_BAD6 = 3'd6,
    FMT_BAD7 = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True when imm[31:msb] are all equal, i.e. imm fits a signed field whose sign bit is msb.
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << msb;
    return ((imm & mask) == mask) || ((imm & mask) == 32'h0);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I packer: scatters the immediate into the instruction word
// for the given format and flags out-of-range immediates or illegal formats.
module imm_pack
  import riscv_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  logic [31:0] raw;
  logic        bad;

  always_comb begin
    // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
    raw = 32'h0;
    bad = 1'b0;
    case (fmt)
      FMT_R: raw = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        raw = {imm[11:0], rs1, funct3, rd, opcode};
        bad = !fits_signed(imm, 11);
      end
      FMT_S: begin
        raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        bad = !fits_signed(imm, 11);
      end
      FMT_B: begin
        raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        bad = !fits_signed(imm, 12) || imm[0];
      end
      FMT_U: begin
        raw = {imm[31:12], rd, opcode};
        bad = |imm[11:0];
      end
      FMT_J: begin
        raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        bad = !fits_signed(imm, 20) || imm[0];
      end
      default: bad = 1'b1;
    endcase
    // Rejected words become a NOP so the program image stays executable.
    instr = bad ? NOP_INSTR : raw;
    err   = bad;
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: one-entry output register with valid/ready on both sides,
// imem word-address counter and saturating count of emitted error words.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_fmt,
  input  logic [6:0]          in_opcode,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic [2:0]          in_funct3,
  input  logic [6:0]          in_funct7,
  input  logic [31:0]         in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_count
);

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e              state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ERRCNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] pk_instr;
  logic        pk_err;
  logic        accept;
  logic        out_hs;

  imm_pack u_imm_pack (
    .fmt    (fmt_e'(in_fmt)),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .instr  (pk_instr),
    .err    (pk_err)
  );

  assign out_valid = (state_q == S_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    if (out_hs) begin
      state_d = S_EMPTY;
      addr_d  = addr_q + ADDR_W'(1);
      if (err_q && (cnt_q != '1)) cnt_d = cnt_q + ERRCNT_W'(1);
    end
    // A new word overrides the drain so a simultaneous handshake keeps the register full.
    if (accept) begin
      state_d = S_FULL;
      instr_d = pk_instr;
      err_d   = pk_err;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= S_EMPTY;
      instr_q <= 32'h0;
      err_q   <= 1'b0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign out_addr  = addr_q;
  assign err_count = cnt_q;

endmodule
